// File: rtl/gate_pkg.sv
// Shared types and constants for the gate event decoder: FSM state set,
// filtered beam-pair encodings and parameter defaults.
package gate_pkg;

    // Parameter defaults used by the top level and the debounce filter.
    localparam int DEBOUNCE_DEFAULT = 4;
    localparam int TIMEOUT_DEFAULT  = 1000;

    // Filtered beam pair, written AB (A = outer beam in the MSB).
    typedef logic [1:0] pair_t;

    localparam pair_t PAIR_CLEAR = 2'b00;
    localparam pair_t PAIR_A     = 2'b10;
    localparam pair_t PAIR_B     = 2'b01;
    localparam pair_t PAIR_BOTH  = 2'b11;

    // Direction tracker states. IDLE must stay at encoding 0 so the reset
    // value and "not busy" coincide.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        IN_A       = 3'd1,
        IN_AB      = 3'd2,
        IN_B       = 3'd3,
        OUT_B      = 3'd4,
        OUT_AB     = 3'd5,
        OUT_A      = 3'd6,
        WAIT_CLEAR = 3'd7
    } state_e;

    // Beam pair that holds steady while the tracker sits in a given state.
    // IDLE and WAIT_CLEAR map to the clear pair; WAIT_CLEAR never uses it.
    function automatic pair_t state_pair(input state_e s);
        pair_t p;
        case (s)
            IN_A, OUT_A:   p = PAIR_A;
            IN_AB, OUT_AB: p = PAIR_BOTH;
            IN_B, OUT_B:   p = PAIR_B;
            default:       p = PAIR_CLEAR;
        endcase
        return p;
    endfunction

    // Mid-sequence states are the only ones guarded by the timeout.
    function automatic logic is_mid_seq(input state_e s);
        return (s != IDLE) && (s != WAIT_CLEAR);
    endfunction

endpackage

// File: rtl/gate_debounce.sv
// Two-flop synchronizer followed by a consecutive-mismatch debounce filter
// for one raw beam sensor. The filtered value flips only after the
// synchronized value has disagreed with it for DEBOUNCE straight cycles.
module gate_debounce
    import gate_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic filt_o
);

    // Counter holds 0..DEBOUNCE-1; the +1 keeps the width non-zero when
    // DEBOUNCE is 1.
    localparam int                CNT_W    = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             filt_q;
    logic             filt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Bring the asynchronous raw input into the clock domain.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, which is what makes
    // sync1_q -> sync2_q a two-stage pipeline instead of a single wire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive mismatches; flip the filtered value on the last one.
    // NOTE: every output of a combinational block is given a default before
    // any branching so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = ~filt_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/gate_event_decoder.sv
// Gate front end: debounces the outer (A) and inner (B) beams, tracks the
// direction of each pass and emits single-cycle add/delete/fault pulses.
// A separate edge detector turns a raw clear request into a load pulse.
module gate_event_decoder
    import gate_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT,
    parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic sens_a,
    input  logic sens_b,
    input  logic clear_req,
    output logic add,
    output logic delete,
    output logic load,
    output logic fault,
    output logic busy
);

    // Timeout counter holds 0..TIMEOUT-1 and fires on the last value.
    localparam int               TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    logic             filt_a;
    logic             filt_b;
    pair_t            pair;

    state_e           state_q;
    state_e           state_d;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_d;
    logic             illegal;
    logic             add_d;
    logic             delete_d;
    logic             fault_d;
    logic             add_q;
    logic             delete_q;
    logic             fault_q;

    logic             clr_sync1_q;
    logic             clr_sync2_q;
    logic             clr_prev_q;
    logic             load_q;

    gate_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_deb_a (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (sens_a),
        .filt_o (filt_a)
    );

    gate_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_deb_b (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (sens_b),
        .filt_o (filt_b)
    );

    assign pair = {filt_a, filt_b};

    // Direction tracker: every state has exactly two one-bit neighbours;
    // a two-bit jump is illegal, and a stalled mid-sequence state times out.
    always_comb begin
        state_d  = state_q;
        illegal  = 1'b0;
        add_d    = 1'b0;
        delete_d = 1'b0;
        fault_d  = 1'b0;

        case (state_q)
            IDLE: begin
                case (pair)
                    PAIR_A:    state_d = IN_A;
                    PAIR_B:    state_d = OUT_B;
                    PAIR_BOTH: illegal = 1'b1;
                    default:   state_d = IDLE;
                endcase
            end
            IN_A: begin
                case (pair)
                    PAIR_CLEAR: state_d = IDLE;
                    PAIR_BOTH:  state_d = IN_AB;
                    PAIR_A:     state_d = IN_A;
                    default:    illegal = 1'b1;
                endcase
            end
            IN_AB: begin
                case (pair)
                    PAIR_A:    state_d = IN_A;
                    PAIR_B:    state_d = IN_B;
                    PAIR_BOTH: state_d = IN_AB;
                    default:   illegal = 1'b1;
                endcase
            end
            IN_B: begin
                case (pair)
                    PAIR_CLEAR: begin
                        state_d = IDLE;
                        add_d   = 1'b1;
                    end
                    PAIR_BOTH:  state_d = IN_AB;
                    PAIR_B:     state_d = IN_B;
                    default:    illegal = 1'b1;
                endcase
            end
            OUT_B: begin
                case (pair)
                    PAIR_CLEAR: state_d = IDLE;
                    PAIR_BOTH:  state_d = OUT_AB;
                    PAIR_B:     state_d = OUT_B;
                    default:    illegal = 1'b1;
                endcase
            end
            OUT_AB: begin
                case (pair)
                    PAIR_B:    state_d = OUT_B;
                    PAIR_A:    state_d = OUT_A;
                    PAIR_BOTH: state_d = OUT_AB;
                    default:   illegal = 1'b1;
                endcase
            end
            OUT_A: begin
                case (pair)
                    PAIR_CLEAR: begin
                        state_d  = IDLE;
                        delete_d = 1'b1;
                    end
                    PAIR_BOTH:  state_d = OUT_AB;
                    PAIR_A:     state_d = OUT_A;
                    default:    illegal = 1'b1;
                endcase
            end
            WAIT_CLEAR: begin
                if (pair == PAIR_CLEAR) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abandon the pass on a two-bit jump, or when a mid-sequence state
        // has seen no filtered change for TIMEOUT cycles.
        if (illegal) begin
            state_d = WAIT_CLEAR;
            fault_d = 1'b1;
        end else if (is_mid_seq(state_q) && (pair == state_pair(state_q)) &&
                     (tmo_cnt_q == TMO_LAST)) begin
            state_d = WAIT_CLEAR;
            fault_d = 1'b1;
        end
    end

    // Timeout counter runs only while a mid-sequence state is held; any
    // transition (including into the state) restarts it from zero.
    always_comb begin
        tmo_cnt_d = '0;
        if (is_mid_seq(state_q) && (state_d == state_q)) begin
            tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        end
    end

    // Tracker state, timeout counter and registered event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tmo_cnt_q <= '0;
            add_q     <= 1'b0;
            delete_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            add_q     <= add_d;
            delete_q  <= delete_d;
            fault_q   <= fault_d;
        end
    end

    // Synchronize clear_req and turn its rising edge into a one-cycle load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_sync1_q <= 1'b0;
            clr_sync2_q <= 1'b0;
            clr_prev_q  <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            clr_sync1_q <= clear_req;
            clr_sync2_q <= clr_sync1_q;
            clr_prev_q  <= clr_sync2_q;
            load_q      <= clr_sync2_q & ~clr_prev_q;
        end
    end

    assign add    = add_q;
    assign delete = delete_q;
    assign fault  = fault_q;
    assign load   = load_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_gate_event_decoder.sv
// Scoreboard bench for gate_event_decoder. A behavioural model (beam pair
// walked along entry/exit path tables, timestamps for the timeout) predicts
// each output pulse and pushes it to a queue; a monitor pops and compares
// whenever the DUT shows a pulse.
module tb_gate_event_decoder;

    localparam int DB = 4;
    localparam int TO = 20;

    logic clk       = 1'b0;
    logic rst       = 1'b0;
    logic sens_a    = 1'b0;
    logic sens_b    = 1'b0;
    logic clear_req = 1'b0;
    logic add_w, del_w, load_w, fault_w, busy_w;

    gate_event_decoder #(
        .DEBOUNCE (DB),
        .TIMEOUT  (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sens_a    (sens_a),
        .sens_b    (sens_b),
        .clear_req (clear_req),
        .add       (add_w),
        .delete    (del_w),
        .load      (load_w),
        .fault     (fault_w),
        .busy      (busy_w)
    );

    always #5 clk = ~clk;

    // Expected pulse: cycle stamp, {add, delete, fault, load}, busy after it.
    typedef struct {
        int         cyc;
        logic [3:0] mask;
        logic       busy;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  dut_add = 0, dut_del = 0, dut_fault = 0, dut_load = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Pass paths as beam-pair sequences: row 0 entry, row 1 exit.
    bit [1:0] path_tab [0:1][0:2] = '{'{2'b10, 2'b11, 2'b01},
                                      '{2'b01, 2'b11, 2'b10}};
    bit m_a1, m_a2, m_b1, m_b2, m_c1, m_c2, m_cprev;
    bit m_fa, m_fb;
    int m_run_a, m_run_b;
    int m_mode;       // 0 idle, 1 entering, 2 exiting, 3 waiting for clear
    int m_pos;        // index along the current path
    int m_last;       // cycle of the last path step

    task automatic model_reset();
        m_a1 = 0; m_a2 = 0; m_b1 = 0; m_b2 = 0;
        m_c1 = 0; m_c2 = 0; m_cprev = 0;
        m_fa = 0; m_fb = 0; m_run_a = 0; m_run_b = 0;
        m_mode = 0; m_pos = 0; m_last = 0;
    endtask

    // One clock edge, using the values everything held just before it.
    task automatic model_step();
        bit [1:0] p, cur;
        bit e_add, e_del, e_fault, e_load;
        ev_t e;
        if (rst) begin
            model_reset();
            return;
        end
        e_add = 0; e_del = 0; e_fault = 0; e_load = 0;
        p = {m_fa, m_fb};

        if (m_mode == 0) begin
            if (p == 2'b10) begin m_mode = 1; m_pos = 0; m_last = cyc; end
            else if (p == 2'b01) begin m_mode = 2; m_pos = 0; m_last = cyc; end
            else if (p == 2'b11) begin m_mode = 3; e_fault = 1; end
        end else if (m_mode == 3) begin
            if (p == 2'b00) m_mode = 0;
        end else begin
            cur = path_tab[m_mode-1][m_pos];
            if (p == cur) begin
                if (cyc - m_last >= TO) begin m_mode = 3; e_fault = 1; end
            end else if ((p ^ cur) == 2'b11) begin
                m_mode = 3; e_fault = 1;
            end else begin
                m_last = cyc;
                if (m_pos < 2 && p == path_tab[m_mode-1][m_pos+1]) m_pos++;
                else if (m_pos > 0 && p == path_tab[m_mode-1][m_pos-1]) m_pos--;
                else begin
                    if (m_pos == 2) begin
                        if (m_mode == 1) e_add = 1; else e_del = 1;
                    end
                    m_mode = 0;
                end
            end
        end

        e_load  = m_c2 && !m_cprev;
        m_cprev = m_c2;

        if (m_a2 != m_fa) begin
            m_run_a++;
            if (m_run_a == DB) begin m_fa = !m_fa; m_run_a = 0; end
        end else m_run_a = 0;
        if (m_b2 != m_fb) begin
            m_run_b++;
            if (m_run_b == DB) begin m_fb = !m_fb; m_run_b = 0; end
        end else m_run_b = 0;

        m_a2 = m_a1; m_a1 = sens_a;
        m_b2 = m_b1; m_b1 = sens_b;
        m_c2 = m_c1; m_c1 = clear_req;

        if (e_add || e_del || e_fault || e_load) begin
            e.cyc  = cyc;
            e.mask = {e_add, e_del, e_fault, e_load};
            e.busy = (m_mode != 0);
            exp_q.push_back(e);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [3:0] m;
        ev_t        e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m = {add_w, del_w, fault_w, load_w};
                dut_add   += int'(add_w);
                dut_del   += int'(del_w);
                dut_fault += int'(fault_w);
                dut_load  += int'(load_w);
                if (m != 4'b0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", int'(m), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_cycle", cyc, e.cyc);
                        check("pulse_kind", int'(m), int'(e.mask));
                        check("busy_at_pulse", int'(busy_w), int'(e.busy));
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    check("missing_pulse", 0, int'(e.mask));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
    endtask

    task automatic hold(input bit a, input bit b, input int n);
        sens_a = a;
        sens_b = b;
        repeat (n) tick();
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (3) tick();
        check("reset_add",    int'(add_w),   0);
        check("reset_delete", int'(del_w),   0);
        check("reset_fault",  int'(fault_w), 0);
        check("reset_load",   int'(load_w),  0);
        check("reset_busy",   int'(busy_w),  0);
        rst = 1'b0;
        hold(0, 0, 5);

        // Clean entry.
        hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10); hold(0, 0, 10);
        check("entry_add_count",   dut_add,   1);
        check("entry_no_delete",   dut_del,   0);
        check("entry_no_fault",    dut_fault, 0);
        check("entry_busy_idle",   int'(busy_w), 0);

        // Clean exit, then a back-out from the entry side.
        hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
        check("exit_delete_count", dut_del, 1);
        hold(1, 0, 10); hold(1, 1, 10);
        check("backout_busy_mid",  int'(busy_w), 1);
        hold(1, 0, 10); hold(0, 0, 10);
        check("backout_add_count", dut_add, 1);
        check("backout_del_count", dut_del, 1);
        check("backout_busy_idle", int'(busy_w), 0);

        // Glitches shorter than the debounce window.
        repeat (3) begin
            hold(1, 0, 3);
            hold(0, 0, 10);
        end
        check("glitch_busy",  int'(busy_w), 0);
        check("glitch_fault", dut_fault, 0);

        // Illegal jump straight to both-blocked.
        hold(1, 1, 20);
        check("illegal_fault_count", dut_fault, 1);
        check("illegal_busy_held",   int'(busy_w), 1);
        hold(0, 0, 15);
        check("illegal_cleared_busy", int'(busy_w), 0);
        check("illegal_no_extra",     dut_fault, 1);

        // Timeout while stuck in IN_A, then a normal entry still counts.
        hold(1, 0, 40);
        check("timeout_fault_count", dut_fault, 2);
        hold(0, 0, 10);
        hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10); hold(0, 0, 10);
        check("after_timeout_add", dut_add, 2);

        // Held clear request yields a single load.
        clear_req = 1'b1;
        hold(0, 0, 50);
        clear_req = 1'b0;
        hold(0, 0, 10);
        check("clear_load_count", dut_load, 1);

        // Reset while in IN_AB, released with both beams still blocked.
        hold(1, 0, 10); hold(1, 1, 10);
        check("pre_reset_busy", int'(busy_w), 1);
        rst = 1'b1;
        #1;
        check("rst_mid_add",    int'(add_w),   0);
        check("rst_mid_delete", int'(del_w),   0);
        check("rst_mid_fault",  int'(fault_w), 0);
        check("rst_mid_load",   int'(load_w),  0);
        check("rst_mid_busy",   int'(busy_w),  0);
        model_reset();
        hold(1, 1, 3);
        rst = 1'b0;
        hold(1, 1, 20);
        check("post_reset_fault", dut_fault, 3);
        check("post_reset_busy",  int'(busy_w), 1);
        hold(0, 0, 15);

        // Randomized beam activity and clear requests.
        for (int i = 0; i < 300; i++) begin
            bit na, nb;
            int r, dur;
            na = sens_a;
            nb = sens_b;
            r  = int'($urandom_range(0, 9));
            if (r < 4) na = !na;
            else if (r < 8) nb = !nb;
            else if (r == 8) begin na = !na; nb = !nb; end
            dur = ($urandom_range(0, 9) == 0) ? 30 : int'($urandom_range(1, 14));
            if ($urandom_range(0, 7) == 0) clear_req = !clear_req;
            hold(na, nb, dur);
        end
        clear_req = 1'b0;
        hold(0, 0, 40);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
